fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder through a valid/ready handshake.
- Accepts PC redirects from branch resolution (B/CBZ/CBNZ) and discards wrong-path instructions, both buffered and in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  // PC width of the canonical fetch entry (matches the default PC_W of fetch_unit).
  localparam int unsigned ENTRY_PC_W = 32;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0]     inst;
    logic [ENTRY_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions. Flush wins over push and pop.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Pointer and occupancy next state; flush empties the FIFO regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Status and head-of-queue outputs.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
    empty_o = (count_q == '0);
    full_o  = (count_q == (PtrW+1)'(Depth));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, an
// instruction buffer towards the decoder, and redirect handling that discards
// wrong-path instructions both buffered and still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int unsigned      CntW     = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned      EntryW   = INST_W + PC_W;
  localparam logic [CntW:0]    DepthVal = (CntW+1)'(BUF_DEPTH);
  localparam logic [PC_W-1:0]  PcInc    = PC_W'(PC_INC);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PC_W-1:0]   redirect_pc_aligned;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, fifo_full;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_drop;
  logic              push, pop;

  // Request credit counts in-flight requests (stale ones included) plus buffered
  // entries, so every response is guaranteed a FIFO slot.
  always_comb begin
    redirect_pc_aligned = redirect_pc & ~PC_W'(3);
    credit_ok      = ((CntW+1)'(outstanding_q) + (CntW+1)'(fifo_count) < DepthVal) && !fifo_full;
    imem_req_valid = !reset && !stall && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response is wrong-path if older than a redirect, including one arriving with it.
    rsp_drop       = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
    push           = imem_rsp_valid && !rsp_drop && !reset;
    pop            = inst_valid && inst_ready && !redirect_valid;
    fifo_wdata     = {imem_rsp_data, rsp_pc_q};
  end

  // Decoder-facing outputs are forced to zero while empty or in reset.
  always_comb begin
    inst_valid = !reset && !fifo_empty;
    inst       = NOP_INST;
    inst_pc    = '0;
    if (inst_valid) begin
      inst    = fifo_rdata[EntryW-1:PC_W];
      inst_pc = fifo_rdata[PC_W-1:0];
    end
  end

  // PC, response PC and in-flight bookkeeping.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (req_fire) pc_d = pc_q + PcInc;
    if (push)     rsp_pc_d = rsp_pc_q + PcInc;

    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc_aligned;
      rsp_pc_d = redirect_pc_aligned;
      // Everything still in flight after this cycle is wrong-path; drop_cnt never
      // exceeds outstanding, so this also covers any drop already pending.
      drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .Width (EntryW),
    .Depth (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;
  logic [31:0] drop_inc;

  // Discards this cycle: a wrong-path response plus whatever a redirect flushes.
  always_comb begin
    drop_inc = 32'(rsp_drop) + (redirect_valid ? 32'(fifo_count) : 32'd0);
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(pop);
      perf_dropped_q <= perf_dropped_q + drop_inc;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit. A transaction-level model tracks
// the PC, a queue of in-flight requests tagged stale/live, and the instruction
// buffer contents; memory is modelled as an in-order queue with configurable latency.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_unit #(
    .PC_W      (32),
    .BUF_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          stale;
    int          due;
  } flight_t;

  flight_t      inflight[$];
  fetch_entry_t buf_q[$];
  logic [31:0]  mpc = RST_PC;
  logic [31:0]  m_fetched = 32'h0;
  logic [31:0]  m_dropped = 32'h0;
  int           cyc = 0;
  int           last_due = 0;
  int           lat = 1;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] rpc,
                      input logic ir, input logic qr);
    logic        rv;
    logic [31:0] rdat;
    logic        exp_req, exp_iv;
    flight_t     f;
    int          flushed;
    @(negedge clk);
    rv   = 1'b0;
    rdat = 32'h0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      rv   = 1'b1;
      rdat = inflight[0].data;
    end
    reset          = rs;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    inst_ready     = ir;
    imem_req_ready = qr;
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? rdat : $urandom;
    #1;
    exp_req = !rs && !st && !rd && (inflight.size() + buf_q.size() < DEPTH);
    exp_iv  = !rs && (buf_q.size() > 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, mpc);
    check("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("inst", inst, buf_q[0].inst);
      check("inst_pc", inst_pc, buf_q[0].pc);
    end else begin
      check("inst_idle", inst, 32'h0);
      check("inst_pc_idle", inst_pc, 32'h0);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_dropped", perf_dropped, m_dropped);
`endif
    // Model state after the coming rising edge.
    if (rs) begin
      if (rv) void'(inflight.pop_front());
      buf_q.delete();
      mpc       = RST_PC;
      m_fetched = 32'h0;
      m_dropped = 32'h0;
    end else begin
      flushed = buf_q.size();
      if (exp_iv && ir && !rd) begin
        void'(buf_q.pop_front());
        m_fetched++;
      end
      if (rv) begin
        f = inflight.pop_front();
        if (f.stale || rd) m_dropped++;
        else buf_q.push_back('{inst: f.data, pc: f.addr});
      end
      if (rd) begin
        buf_q.delete();
        m_dropped += 32'(flushed);
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        mpc = rpc & 32'hFFFF_FFFC;
      end
      if (exp_req && qr) begin
        f.addr  = mpc;
        f.data  = $urandom;
        f.stale = 1'b0;
        f.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = f.due;
        inflight.push_back(f);
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic st, input logic ir);
    for (int i = 0; i < n; i++) step(1'b0, st, 1'b0, 32'h0, ir, 1'b1);
  endtask

  // Long enough for every in-flight response to arrive while reset is still high.
  task automatic do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    inflight.delete();
  endtask

  initial begin
    logic [31:0] rpc;
    // Reset, then 1-cycle always-ready memory: sequential fetch from RESET_PC.
    lat = 1;
    do_reset();
    run(6, 1'b0, 1'b1);
    // Decoder back-pressure fills the buffer and stops requests; release resumes in order.
    run(6, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1);
    // 3-cycle memory with requests in flight, then a redirect to an unaligned target.
    lat = 3;
    run(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_2002, 1'b1, 1'b1);
    run(12, 1'b0, 1'b1);
    // Redirect coinciding with a response and a pop.
    lat = 1;
    run(4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1);
    // Stall with responses pending, then resume.
    lat = 2;
    run(3, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1);
    // Redirect together with stall, then release.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    run(3, 1'b1, 1'b1);
    run(8, 1'b0, 1'b1);
    // Reset mid-fetch with requests in flight.
    lat = 3;
    run(2, 1'b0, 1'b1);
    do_reset();
    run(8, 1'b0, 1'b1);
    // Randomized traffic, including PC wrap and one mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      if (i == 700) do_reset();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else rpc = $urandom;
      step(1'b0, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
